// File: rtl/branch_resolve_unit.sv
// Checks fetch-predicted branches, in program order, against execute outcomes.
// Drives flush/redirect on a mispredict and trains the predictor on every resolve.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic [XLEN-1:0]  pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  state_t          state;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            mispred;

  assign head       = mem[rd_ptr];
  assign pred_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign push       = pred_valid & pred_ready;
  assign pop        = (state == IDLE) & res_valid & (count != '0);
  assign mispred    = (res_taken != head.taken)
                    | (res_taken & (res_target != head.target));
  assign busy       = (count != '0) | (state != IDLE);

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{taken: pred_taken, pc: pred_pc, target: pred_target};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      timer       <= '0;
      state       <= IDLE;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      upd_valid <= 1'b0;
      flush     <= 1'b0;
      if (pop) begin
        upd_valid <= 1'b1;
        upd_pc    <= head.pc;
        upd_taken <= res_taken;
        if (branch_cnt != {CNT_W{1'b1}})
          branch_cnt <= branch_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (pop && mispred) begin
            // Any same-cycle push is wrong-path and is dropped.
            flush       <= 1'b1;
            redirect_pc <= res_taken ? res_target
                                     : head.pc + XLEN'(4);
            if (mispred_cnt != {CNT_W{1'b1}})
              mispred_cnt <= mispred_cnt + CNT_W'(1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= FLUSH;
            timer  <= TW'(FLUSH_CYCLES);
          end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
              count <= count + CW'(1);
            else if (pop && !push)
              count <= count - CW'(1);
          end
        end
        FLUSH: begin
          if (timer <= TW'(1)) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a reference queue model
// and an expected-update scoreboard.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_valid = 1'b0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_pc = '0;
  logic [31:0] pred_target = '0;
  logic        pred_ready;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_target(pred_target),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        taken;
    bit [31:0] pc;
    bit [31:0] target;
  } ent_t;

  typedef struct {
    bit [31:0] pc;
    bit        taken;
    bit        mis;
    bit [31:0] rpc;
  } exp_t;

  ent_t  mq[$];
  exp_t  sbq[$];
  int    m_timer = 0;
  bit [15:0] m_br = '0;
  bit [15:0] m_mp = '0;
  int    passed = 0;
  int    total = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    bit   rdy;
    bit   push_m;
    bit   pop_m;
    bit   mis;
    ent_t h;
    ent_t n;
    exp_t e;
    push_m = 0;
    pop_m  = 0;
    mis    = 0;
    rdy    = (m_timer == 0) && (mq.size() < 4);
    if (rst) begin
      mq.delete();
      sbq.delete();
      m_timer = 0;
      m_br    = '0;
      m_mp    = '0;
    end else begin
      chk("pred_ready", pred_ready, rdy);
      chk("busy", busy, (mq.size() != 0) || (m_timer != 0));
      push_m = pred_valid && rdy;
      pop_m  = res_valid && (m_timer == 0) && (mq.size() > 0);
      if (m_timer > 0) m_timer--;
      if (pop_m) begin
        h = mq.pop_front();
        mis = (res_taken != h.taken)
           || (res_taken && (res_target != h.target));
        e.pc    = h.pc;
        e.taken = res_taken;
        e.mis   = mis;
        e.rpc   = res_taken ? res_target : h.pc + 32'd4;
        sbq.push_back(e);
        if (m_br != 16'hffff) m_br++;
        if (mis && m_mp != 16'hffff) m_mp++;
      end
      if (mis) begin
        mq.delete();
        m_timer = 2;
      end else if (push_m) begin
        n.taken  = pred_taken;
        n.pc     = pred_pc;
        n.target = pred_target;
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    if (pop_m && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("upd_valid", upd_valid, 1);
      chk("upd_pc", upd_pc, e.pc);
      chk("upd_taken", upd_taken, e.taken);
      chk("flush", flush, e.mis);
      if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
    end else begin
      chk("upd_idle", upd_valid, 0);
      chk("flush_idle", flush, 0);
    end
    chk("branch_cnt", branch_cnt, m_br);
    chk("mispred_cnt", mispred_cnt, m_mp);
  endtask

  task automatic cyc(bit pv, bit pt, logic [31:0] ppc,
                     logic [31:0] ptg, bit rv, bit rt,
                     logic [31:0] rtg);
    pred_valid  = pv;
    pred_taken  = pt;
    pred_pc     = ppc;
    pred_target = ptg;
    res_valid   = rv;
    res_taken   = rt;
    res_target  = rtg;
    tick();
    pred_valid = 0;
    pred_taken = 0;
    pred_pc    = '0;
    pred_target = '0;
    res_valid  = 0;
    res_taken  = 0;
    res_target = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // T1 reset
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_upd_pc", upd_pc, 32'h0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_ready", pred_ready, 1);
    chk("rst_busy", busy, 0);
    idle(1);
    // T2 correct not-taken
    cyc(1, 0, 32'h100, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    idle(1);
    // T3 not-taken predicted, actually taken
    cyc(1, 0, 32'h200, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h240);
    idle(3);
    // T4 taken predicted, not taken; then wrong target
    cyc(1, 1, 32'h300, 32'h380, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    idle(3);
    cyc(1, 1, 32'h310, 32'h380, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h390);
    idle(3);
    // T5 fill, correct pop with blocked push, then refill
    cyc(1, 0, 32'h400, 32'h0, 0, 0, 32'h0);
    cyc(1, 1, 32'h404, 32'h500, 0, 0, 32'h0);
    cyc(1, 0, 32'h408, 32'h0, 0, 0, 32'h0);
    cyc(1, 1, 32'h40c, 32'h600, 0, 0, 32'h0);
    chk("full_ready", pred_ready, 0);
    cyc(1, 0, 32'h410, 32'h0, 1, 0, 32'h0);
    cyc(1, 0, 32'h414, 32'h0, 0, 0, 32'h0);
    chk("refill_ready", pred_ready, 0);
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h500);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h600);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    // resolve on empty queue is ignored
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h700);
    chk("empty_busy", busy, 0);
    // T6 mispredict with same-cycle push, ignored res in FLUSH
    cyc(1, 0, 32'h800, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 32'h804, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 32'h808, 32'h0, 1, 1, 32'h880);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    idle(2);
    chk("post_flush_busy", busy, 0);
    // reset in the middle of FLUSH
    cyc(1, 1, 32'h900, 32'h940, 0, 0, 32'h0);
    cyc(1, 0, 32'h904, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    chk("flush_state_busy", busy, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_flush_ready", pred_ready, 1);
    chk("rst_flush_busy", busy, 0);
    idle(2);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
